// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the memory controller.
// Build option: MEM_LOAD_FWD_EN enables store-to-load forwarding.
package mem_ctrl_pkg;

    localparam int unsigned WORD_WIDTH        = 32;
    localparam int unsigned MEM_WORDS_DEFAULT = 1024;
    localparam int unsigned SB_DEPTH_DEFAULT  = 4;

    typedef enum logic {
        MC_NORMAL = 1'b0,
        MC_FLUSH  = 1'b1
    } mc_state_e;

endpackage

// File: rtl/mem_ctrl_store_buffer.sv
// FIFO store buffer with per-entry word-address compare for load lookup.
// Build option: MEM_LOAD_FWD_EN adds the youngest-match forwarding data path.
module mem_ctrl_store_buffer #(
    parameter  int unsigned W     = 32,
    parameter  int unsigned AW    = 10,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic [AW-1:0] enq_addr,
    input  logic [W-1:0]  enq_data,
    input  logic          deq,
    input  logic [AW-1:0] lookup_addr,
    output logic [AW-1:0] head_addr,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          hit
`ifdef MEM_LOAD_FWD_EN
    ,
    output logic [W-1:0]  fwd_data
`endif
);

    logic [AW-1:0] addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Pointer/occupancy tracking; simultaneous enq+deq leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            assert (!(enq && !deq && count == CW'(DEPTH)));
            assert (!(deq && count == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= enq_addr;
            data_q[tail] <= enq_data;
        end
    end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

    // Walk oldest to youngest so the last valid match is the youngest
    always_comb begin
        hit = 1'b0;
`ifdef MEM_LOAD_FWD_EN
        fwd_data = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && addr_q[head + PW'(i)] == lookup_addr) begin
                hit = 1'b1;
`ifdef MEM_LOAD_FWD_EN
                fwd_data = data_q[head + PW'(i)];
`endif
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Word-addressed RAM responder for fetch/load/store with a draining store buffer.
// Build option: MEM_LOAD_FWD_EN forwards buffered stores to loads; otherwise matching loads stall.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int unsigned W         = WORD_WIDTH,
    parameter  int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter  int unsigned SB_DEPTH  = SB_DEPTH_DEFAULT,
    localparam int unsigned AW        = $clog2(MEM_WORDS),
    localparam int unsigned CW        = $clog2(SB_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    output logic [W-1:0] read_inst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    input  logic         sb_flush,
    output logic         flush_done,
    output logic         mem_stall,
    output logic         sb_empty
);

    logic [W-1:0]  ram [MEM_WORDS];
    mc_state_e     state;
    mc_state_e     state_n;
    logic [AW-1:0] pc_idx;
    logic [AW-1:0] l_idx;
    logic [AW-1:0] s_idx;
    logic [AW-1:0] sb_head_addr;
    logic [W-1:0]  sb_head_data;
    logic [CW-1:0] sb_count;
    logic          sb_full;
    logic          sb_hit;
    logic          hit_stall;
    logic          enq;
    logic          deq;
    logic          unused_addr_bits;

    // Byte offset and bits above the RAM index are dropped (address wraps)
    assign pc_idx = pc[AW+1:2];
    assign l_idx  = l_addr[AW+1:2];
    assign s_idx  = s_addr[AW+1:2];
    assign unused_addr_bits = ^{pc[W-1:AW+2], pc[1:0], l_addr[W-1:AW+2], l_addr[1:0],
                                s_addr[W-1:AW+2], s_addr[1:0]};

`ifdef MEM_LOAD_FWD_EN
    logic [W-1:0] sb_fwd_data;
    assign hit_stall = 1'b0;
`else
    assign hit_stall = load_en && sb_hit;
`endif

    mem_ctrl_store_buffer #(
        .W     (W),
        .AW    (AW),
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .enq         (enq),
        .enq_addr    (s_idx),
        .enq_data    (s_data),
        .deq         (deq),
        .lookup_addr (l_idx),
        .head_addr   (sb_head_addr),
        .head_data   (sb_head_data),
        .count       (sb_count),
        .full        (sb_full),
        .empty       (sb_empty),
        .hit         (sb_hit)
`ifdef MEM_LOAD_FWD_EN
        ,
        .fwd_data    (sb_fwd_data)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MC_NORMAL;
        else     state <= state_n;
    end

    // Flush FSM, stall decision and buffer enqueue/drain control
    always_comb begin
        state_n    = state;
        mem_stall  = 1'b0;
        flush_done = 1'b0;
        deq        = 1'b0;
        case (state)
            MC_NORMAL: begin
                mem_stall = (store_en && sb_full && load_en) || hit_stall;
                deq       = (sb_count != '0) && (!load_en || hit_stall);
                if (sb_flush) state_n = MC_FLUSH;
            end
            MC_FLUSH: begin
                mem_stall = load_en || store_en;
                deq       = (sb_count != '0);
                if (sb_count <= CW'(1)) begin
                    state_n    = MC_NORMAL;
                    flush_done = 1'b1;
                end
            end
            default: state_n = MC_NORMAL;
        endcase
        enq = store_en && !mem_stall;
        if (rst) begin
            enq = 1'b0;
            deq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (deq) ram[sb_head_addr] <= sb_head_data;
    end

    assign read_inst = rst ? '0 : ram[pc_idx];

    always_comb begin
        l_data = '0;
        if (load_en && !mem_stall) begin
`ifdef MEM_LOAD_FWD_EN
            l_data = sb_hit ? sb_fwd_data : ram[l_idx];
`else
            l_data = ram[l_idx];
`endif
        end
    end

endmodule
